// File: rtl/zregfile.sv
// Parametrised register file: one synchronous write port, two registered read ports,
// optional write-to-read bypass, optional hardwired-zero register 0, clear and dirty mask.
`timescale 1ns/1ps
module zregfile #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic              RE_A,
  input  logic [ADDR_W-1:0] RADDR_A,
  output logic [WIDTH-1:0]  RDATA_A,
  output logic              VALID_A,
  input  logic              RE_B,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [WIDTH-1:0]  RDATA_B,
  output logic              VALID_B,
  output logic [DEPTH-1:0]  DIRTY
);

  // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic [WIDTH-1:0] stored_a, stored_b;
  logic             wr_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  function automatic logic [WIDTH-1:0] pick(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              clr,
    input logic              wr,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata
  );
    logic [WIDTH-1:0] v;
    if (!in_range(addr))                      v = '0;
    else if (ZERO_REG && (addr == '0))        v = '0;
    else if (BYPASS && clr)                   v = '0;
    else if (BYPASS && wr && (waddr == addr)) v = wdata;
    else                                      v = stored;
    return v;
  endfunction

  assign wr_ok = WE && !CLR && in_range(WADDR) && !(ZERO_REG && (WADDR == '0));

  // Decoded loops rather than direct indexing keep out-of-range addresses off the array.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (RADDR_A == ADDR_W'(i)) stored_a = regs_q[i];
      if (RADDR_B == ADDR_W'(i)) stored_b = regs_q[i];
    end
  end

  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    if (CLR) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_d[i] = '0;
      dirty_d = '0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (WADDR == ADDR_W'(i)) begin
          regs_d[i]  = WDATA;
          dirty_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    valid_a_d = RE_A;
    valid_b_d = RE_B;
    if (RE_A) rdata_a_d = pick(RADDR_A, stored_a, CLR, wr_ok, WADDR, WDATA);
    if (RE_B) rdata_b_d = pick(RADDR_B, stored_b, CLR, wr_ok, WADDR, WDATA);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      dirty_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      dirty_q   <= dirty_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  assign RDATA_A = rdata_a_q;
  assign RDATA_B = rdata_b_q;
  assign VALID_A = valid_a_q;
  assign VALID_B = valid_b_q;
  assign DIRTY   = dirty_q;

endmodule

// File: tb/tb_zregfile.sv
// Bench for zregfile: four configurations share one stimulus stream and are checked
// every cycle against an array-based reference model, plus literal spot checks.
`timescale 1ns/1ps
module tb_zregfile;

  localparam int NI = 4;
  localparam int MW [NI] = '{8, 8, 16, 8};
  localparam int MD [NI] = '{4, 4, 8, 3};
  localparam int MA [NI] = '{2, 2, 3, 2};
  localparam int MZ [NI] = '{0, 0, 1, 0};
  localparam int MB [NI] = '{1, 0, 1, 1};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n = 1'b0;
  logic        clr, we, re_a, re_b;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rda0, rdb0, rda1, rdb1, rda3, rdb3;
  logic [15:0] rda2, rdb2;
  logic [3:0]  dty0, dty1;
  logic [7:0]  dty2;
  logic [2:0]  dty3;
  logic [15:0] o_rda [NI];
  logic [15:0] o_rdb [NI];
  logic        o_va  [NI];
  logic        o_vb  [NI];
  logic [7:0]  o_dty [NI];

  zregfile #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u0 (
    .CLK(CLK), .RST_N(rst_n), .CLR(clr), .WE(we), .WADDR(waddr[1:0]), .WDATA(wdata[7:0]),
    .RE_A(re_a), .RADDR_A(raddr_a[1:0]), .RDATA_A(rda0), .VALID_A(o_va[0]),
    .RE_B(re_b), .RADDR_B(raddr_b[1:0]), .RDATA_B(rdb0), .VALID_B(o_vb[0]), .DIRTY(dty0));
  zregfile #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .CLK(CLK), .RST_N(rst_n), .CLR(clr), .WE(we), .WADDR(waddr[1:0]), .WDATA(wdata[7:0]),
    .RE_A(re_a), .RADDR_A(raddr_a[1:0]), .RDATA_A(rda1), .VALID_A(o_va[1]),
    .RE_B(re_b), .RADDR_B(raddr_b[1:0]), .RDATA_B(rdb1), .VALID_B(o_vb[1]), .DIRTY(dty1));
  zregfile #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u2 (
    .CLK(CLK), .RST_N(rst_n), .CLR(clr), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RE_A(re_a), .RADDR_A(raddr_a), .RDATA_A(rda2), .VALID_A(o_va[2]),
    .RE_B(re_b), .RADDR_B(raddr_b), .RDATA_B(rdb2), .VALID_B(o_vb[2]), .DIRTY(dty2));
  zregfile #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u3 (
    .CLK(CLK), .RST_N(rst_n), .CLR(clr), .WE(we), .WADDR(waddr[1:0]), .WDATA(wdata[7:0]),
    .RE_A(re_a), .RADDR_A(raddr_a[1:0]), .RDATA_A(rda3), .VALID_A(o_va[3]),
    .RE_B(re_b), .RADDR_B(raddr_b[1:0]), .RDATA_B(rdb3), .VALID_B(o_vb[3]), .DIRTY(dty3));

  assign o_rda[0] = {8'h00, rda0};
  assign o_rdb[0] = {8'h00, rdb0};
  assign o_rda[1] = {8'h00, rda1};
  assign o_rdb[1] = {8'h00, rdb1};
  assign o_rda[2] = rda2;
  assign o_rdb[2] = rdb2;
  assign o_rda[3] = {8'h00, rda3};
  assign o_rdb[3] = {8'h00, rdb3};
  assign o_dty[0] = {4'h0, dty0};
  assign o_dty[1] = {4'h0, dty1};
  assign o_dty[2] = dty2;
  assign o_dty[3] = {5'h00, dty3};

  // Reference model: post-edge state of every instance.
  logic [15:0] m_reg [NI][8];
  logic [15:0] m_ra  [NI];
  logic [15:0] m_rb  [NI];
  logic        m_va  [NI];
  logic        m_vb  [NI];
  logic [7:0]  m_dty [NI];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      for (int r = 0; r < 8; r++) m_reg[k][r] = '0;
      m_ra[k] = '0; m_rb[k] = '0; m_va[k] = 1'b0; m_vb[k] = 1'b0; m_dty[k] = '0;
    end
  endtask

  function automatic logic [15:0] mread(int k, int ra, bit eff, int wa, logic [15:0] wd);
    if (ra >= MD[k]) return 16'h0;
    if (MZ[k] != 0 && ra == 0) return 16'h0;
    if (MB[k] != 0 && clr) return 16'h0;
    if (MB[k] != 0 && eff && wa == ra) return wd;
    return m_reg[k][ra];
  endfunction

  // Advance the model by the edge that will sample the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int          am  = (1 << MA[k]) - 1;
      logic [15:0] dm  = (MW[k] == 16) ? 16'hFFFF : 16'h00FF;
      int          wa  = int'(waddr) & am;
      int          rai = int'(raddr_a) & am;
      int          rbi = int'(raddr_b) & am;
      logic [15:0] wd  = wdata & dm;
      bit          eff = we && !clr && (wa < MD[k]) && !(MZ[k] != 0 && wa == 0);
      logic [15:0] na  = mread(k, rai, eff, wa, wd);
      logic [15:0] nb  = mread(k, rbi, eff, wa, wd);
      if (re_a) m_ra[k] = na;
      if (re_b) m_rb[k] = nb;
      m_va[k] = re_a;
      m_vb[k] = re_b;
      if (clr) begin
        for (int r = 0; r < 8; r++) m_reg[k][r] = '0;
        m_dty[k] = '0;
      end else if (eff) begin
        m_reg[k][wa] = wd;
        m_dty[k][wa] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    clr = 0; we = 0; re_a = 0; re_b = 0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    #2;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.RDATA_A", k), o_rda[k], m_ra[k]);
      chk($sformatf("u%0d.RDATA_B", k), o_rdb[k], m_rb[k]);
      chk($sformatf("u%0d.VALID_A", k), {15'h0, o_va[k]}, {15'h0, m_va[k]});
      chk($sformatf("u%0d.VALID_B", k), {15'h0, o_vb[k]}, {15'h0, m_vb[k]});
      chk($sformatf("u%0d.DIRTY", k), {8'h00, o_dty[k]}, {8'h00, m_dty[k]});
    end
  end

  initial begin
    idle();
    model_clear();
    @(negedge CLK);
    tick(); tick();
    chk("reset RDATA_A", o_rda[0], 16'h0);
    chk("reset RDATA_B", o_rdb[0], 16'h0);
    chk("reset VALID", {14'h0, o_va[0], o_vb[0]}, 16'h0);
    chk("reset DIRTY", {8'h00, o_dty[0]}, 16'h0);
    rst_n = 1'b1;

    we = 1; waddr = 3'd2; wdata = 16'h00A5; tick();
    waddr = 3'd1; wdata = 16'h003C; tick();
    we = 0; re_a = 1; raddr_a = 3'd2; re_b = 1; raddr_b = 3'd1; tick();
    chk("wr/rd RDATA_A", o_rda[0], 16'h00A5);
    chk("wr/rd RDATA_B", o_rdb[0], 16'h003C);
    chk("wr/rd VALID", {14'h0, o_va[0], o_vb[0]}, 16'h0003);
    chk("wr/rd DIRTY", {8'h00, o_dty[0]}, 16'h0006);
    idle(); tick();
    chk("idle VALID_A", {15'h0, o_va[0]}, 16'h0);
    chk("idle RDATA_A hold", o_rda[0], 16'h00A5);

    we = 1; waddr = 3'd3; wdata = 16'h0011; tick();
    wdata = 16'h0077; re_a = 1; raddr_a = 3'd3; tick();
    chk("bypass on", o_rda[0], 16'h0077);
    chk("bypass off old", o_rda[1], 16'h0011);
    chk("oor read data", o_rda[3], 16'h0);
    chk("oor read valid", {15'h0, o_va[3]}, 16'h0001);
    chk("oor DIRTY", {8'h00, o_dty[3]}, 16'h0006);
    we = 0; tick();
    chk("bypass off new", o_rda[1], 16'h0077);

    clr = 1; we = 1; waddr = 3'd1; wdata = 16'h00FF; re_a = 1; raddr_a = 3'd1; tick();
    chk("clr bypass read", o_rda[0], 16'h0);
    chk("clr nobypass read", o_rda[1], 16'h003C);
    chk("clr DIRTY", {8'h00, o_dty[0]}, 16'h0);
    idle();
    for (int a = 0; a < 4; a++) begin
      re_a = 1; raddr_a = 3'(a); tick();
      chk($sformatf("clr reg%0d", a), o_rda[0], 16'h0);
    end

    idle(); we = 1; waddr = 3'd0; wdata = 16'hBEEF; tick();
    waddr = 3'd7; tick();
    we = 0; re_a = 1; raddr_a = 3'd0; re_b = 1; raddr_b = 3'd7; tick();
    chk("zero reg read", o_rda[2], 16'h0);
    chk("reg7 read", o_rdb[2], 16'hBEEF);
    chk("zero DIRTY", {8'h00, o_dty[2]}, 16'h0080);

    idle(); we = 1; waddr = 3'd2; wdata = 16'h00A5; tick();
    we = 0; re_a = 1; raddr_a = 3'd2; tick();
    chk("pre-reset VALID_A", {15'h0, o_va[0]}, 16'h0001);
    chk("pre-reset RDATA_A", o_rda[0], 16'h00A5);
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    chk("async RDATA_A", o_rda[0], 16'h0);
    chk("async VALID_A", {15'h0, o_va[0]}, 16'h0);
    chk("async DIRTY", {8'h00, o_dty[0]}, 16'h0);
    @(negedge CLK);
    tick();
    rst_n = 1'b1;
    re_a = 1; raddr_a = 3'd2; tick();
    chk("post-reset reg2", o_rda[0], 16'h0);
    chk("post-reset VALID_A", {15'h0, o_va[0]}, 16'h0001);

    for (int n = 0; n < 400; n++) begin
      clr     = ($urandom_range(15) == 0);
      we      = 1'($urandom_range(1));
      waddr   = 3'($urandom_range(7));
      wdata   = 16'($urandom);
      re_a    = 1'($urandom_range(1));
      re_b    = 1'($urandom_range(1));
      raddr_a = 3'($urandom_range(7));
      raddr_b = ($urandom_range(3) == 0) ? raddr_a : 3'($urandom_range(7));
      tick();
    end

    idle(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
